// File: rtl/u_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : u_sum_accumulator
// Description : Frame accumulator placed directly after the 12-bit unsigned
//               ripple-carry adder. It takes the adder's 13-bit result (sum
//               plus carry-out) under a valid/ready handshake. It adds a
//               programmable number of those results into a wider wrapping
//               register. It then presents the frame total and a sticky
//               overflow flag on a valid/ready output port.
//
// Ports       : clk        rising-edge clock
//               rst        asynchronous reset, active-high
//               clear      synchronous abort of the current frame/result
//               len        samples per frame, captured on a frame's first accept
//               in_valid   in_sum carries a sample
//               in_ready   stage can take a sample this cycle
//               in_sum     unsigned adder result (IN_W bits)
//               out_valid  out_acc/out_ovf hold a completed frame
//               out_ready  downstream takes the result
//               out_acc    frame total modulo 2^ACC_W (0 when out_valid=0)
//               out_ovf    frame total exceeded 2^ACC_W-1 (0 when out_valid=0)
//               busy       a frame is in progress or awaiting emit
//
// Revision    : 1.0 - initial release
// ============================================================================
module u_sum_accumulator #(
    parameter int IN_W    = 13,
    parameter int ACC_W   = 20,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic               out_ovf,
    output logic               busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a frame's first sample
    localparam logic [1:0] S_ACC  = 2'd1;  // collecting the rest of the frame
    localparam logic [1:0] S_DONE = 2'd2;  // holding the result until emitted

    localparam logic [COUNT_W-1:0] C_CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] C_CNT_ZERO = '0;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] w_cnt_nxt;
    logic [COUNT_W-1:0] r_len_q;
    logic [COUNT_W-1:0] w_len_q_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0]   w_in_acc;    // in_sum zero-extended to accumulator width
    logic [ACC_W:0]     w_sum;       // one extra bit exposes the wrap carry
    logic [COUNT_W-1:0] w_len_eff;   // a requested length of 0 means 1 sample
    logic [COUNT_W-1:0] w_cnt_inc;
    logic               w_accept;
    logic               w_emit;

    // The adder result is unsigned; zero-extend, never sign-extend.
    assign w_in_acc  = {{(ACC_W-IN_W){1'b0}}, in_sum};
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_in_acc};
    assign w_len_eff = (len == C_CNT_ZERO) ? C_CNT_ONE : len;
    assign w_cnt_inc = r_cnt + C_CNT_ONE;

    // ------------------------------------------------------------------------
    // Handshake outputs, decoded straight from the state register so they
    // never depend combinationally on any input.
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_acc   = out_valid ? r_acc : '0;
    assign out_ovf   = out_valid & r_ovf;

    // clear outranks both handshakes: a sample offered during clear is
    // dropped even though in_ready may read 1.
    assign w_accept = in_valid & in_ready & ~clear;
    assign w_emit   = out_valid & out_ready & ~clear;

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_len_q_nxt = r_len_q;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // First sample loads rather than adds, so the previous
                    // frame's total never leaks into this one.
                    w_acc_nxt   = w_in_acc;
                    w_ovf_nxt   = 1'b0;
                    w_cnt_nxt   = C_CNT_ONE;
                    w_len_q_nxt = w_len_eff;
                    w_state_nxt = (w_len_eff == C_CNT_ONE) ? S_DONE : S_ACC;
                end
            end

            S_ACC: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = w_cnt_inc;
                    // cnt only reaches len_q here, so it can never wrap.
                    if (w_cnt_inc == r_len_q) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (w_emit) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len_q <= w_len_q_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule
`default_nettype wire
